mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous data RAM between the instruction-fetch requester and the load/store requester.
- Sequences all accesses. Sub-word stores are done internally as a read-modify-write, so requesters see one uniform req/ack handshake.
- Sits between the core pipeline and the RAM macro; it replaces the stall logic inside the memory wrapper.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states, access sizes,
// and the alignment rule applied when MEM_ARB_MISALIGN_TRAP_EN is defined.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    I_RSP,
    D_RSP,
    RMW_WR,
    D_DONE
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int TYPE_UNSIGNED_BIT = 2;

  // Size 2'b11 has no meaning, so it is reported as illegal alongside misalignment.
  function automatic logic isIllegalAccess(input logic [1:0] size, input logic [1:0] addrLow);
    case (size)
      SZ_BYTE: isIllegalAccess = 1'b0;
      SZ_HALF: isIllegalAccess = addrLow[0];
      SZ_WORD: isIllegalAccess = (addrLow != 2'b00);
      default: isIllegalAccess = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: load extract with sign/zero extension, and the
// sub-word merge used by the read-modify-write store path.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [31:0] ramData_i,
  input  logic [1:0]  addrLow_i,
  input  logic [2:0]  loadType_i,
  input  logic [15:0] storeData_i,
  input  logic [1:0]  storeSize_i,
  output logic [31:0] loadData_o,
  output logic [31:0] mergeData_o
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;
  logic        signExt;

  assign byteVal = ramData_i[{addrLow_i, 3'b000} +: 8];
  assign halfVal = ramData_i[{addrLow_i[1], 4'b0000} +: 16];
  assign signExt = ~loadType_i[TYPE_UNSIGNED_BIT];

  // Size 2'b11 falls into the word case, matching the non-trapping behaviour.
  always_comb begin
    loadData_o = ramData_i;
    case (loadType_i[1:0])
      SZ_BYTE: loadData_o = {{24{signExt & byteVal[7]}}, byteVal};
      SZ_HALF: loadData_o = {{16{signExt & halfVal[15]}}, halfVal};
      default: loadData_o = ramData_i;
    endcase
  end

  always_comb begin
    mergeData_o = ramData_i;
    case (storeSize_i)
      SZ_BYTE: mergeData_o[{addrLow_i, 3'b000} +: 8] = storeData_i[7:0];
      SZ_HALF: mergeData_o[{addrLow_i[1], 4'b0000} +: 16] = storeData_i;
      default: mergeData_o = ramData_i;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store, doing sub-word
// stores as read-modify-write. Define MEM_ARB_MISALIGN_TRAP_EN to reject bad data accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              cpu_clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_type,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_q
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  starveCnt_q, starveCnt_d;
  logic [ADDR_W+1:0] reqAddr_q, reqAddr_d;
  logic [2:0]        reqType_q, reqType_d;
  logic [15:0]       reqWdata_q, reqWdata_d;
  logic              trapErr_q, trapErr_d;

  logic              dataTrap;
  logic [31:0]       loadData;
  logic [31:0]       mergeData;
  logic              unusedAddrBits;

  assign unusedAddrBits = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2]};

`ifdef MEM_ARB_MISALIGN_TRAP_EN
  assign dataTrap = isIllegalAccess(d_type[1:0], d_addr[1:0]);
`else
  assign dataTrap = 1'b0;
`endif

  mem_lane_align uAlign (
    .ramData_i   (ram_q),
    .addrLow_i   (reqAddr_q[1:0]),
    .loadType_i  (reqType_q),
    .storeData_i (reqWdata_q),
    .storeSize_i (reqType_q[1:0]),
    .loadData_o  (loadData),
    .mergeData_o (mergeData)
  );

  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starveCnt_q <= '0;
      reqAddr_q   <= '0;
      reqType_q   <= '0;
      reqWdata_q  <= '0;
      trapErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
      reqAddr_q   <= reqAddr_d;
      reqType_q   <= reqType_d;
      reqWdata_q  <= reqWdata_d;
      trapErr_q   <= trapErr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    starveCnt_d = starveCnt_q;
    reqAddr_d   = reqAddr_q;
    reqType_d   = reqType_q;
    reqWdata_d  = reqWdata_q;
    trapErr_d   = trapErr_q;
    ram_addr    = reqAddr_q[ADDR_W+1:2];
    ram_rden    = 1'b0;
    ram_wren    = 1'b0;
    ram_wdata   = '0;
    i_ack       = 1'b0;
    i_rdata     = '0;
    d_ack       = 1'b0;
    d_rdata     = '0;
    d_err       = 1'b0;

    if (!i_req) starveCnt_d = '0;

    case (state_q)
      IDLE: begin
        if (i_req && (!d_req || starveCnt_q == CNT_LIMIT)) begin
          ram_rden    = 1'b1;
          ram_addr    = i_addr[ADDR_W+1:2];
          starveCnt_d = '0;
          state_d     = I_RSP;
        end else if (d_req) begin
          reqAddr_d  = d_addr[ADDR_W+1:0];
          reqType_d  = d_type;
          reqWdata_d = d_wdata[15:0];
          trapErr_d  = dataTrap;
          ram_addr   = d_addr[ADDR_W+1:2];
          if (i_req) starveCnt_d = starveCnt_q + 1'b1;
          // d_type[1] set means a full word: 2'b11 only gets here when not trapping
          if (dataTrap) begin
            state_d = D_DONE;
          end else if (!d_we) begin
            ram_rden = 1'b1;
            state_d  = D_RSP;
          end else if (d_type[1]) begin
            ram_wren  = 1'b1;
            ram_wdata = d_wdata;
            state_d   = D_DONE;
          end else begin
            ram_rden = 1'b1;
            state_d  = RMW_WR;
          end
        end
      end
      I_RSP: begin
        i_ack   = 1'b1;
        i_rdata = ram_q;
        state_d = IDLE;
      end
      D_RSP: begin
        d_ack   = 1'b1;
        d_rdata = loadData;
        state_d = IDLE;
      end
      RMW_WR: begin
        ram_wren  = 1'b1;
        ram_wdata = mergeData;
        state_d   = D_DONE;
      end
      D_DONE: begin
        d_ack   = 1'b1;
        d_err   = trapErr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset suppresses everything visible, including an RMW write already scheduled.
    if (rst) begin
      ram_rden  = 1'b0;
      ram_wren  = 1'b0;
      ram_wdata = '0;
      i_ack     = 1'b0;
      i_rdata   = '0;
      d_ack     = 1'b0;
      d_rdata   = '0;
      d_err     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed timing cases, contention/starvation, and
// randomized traffic against a word-array reference model. Honours MEM_ARB_MISALIGN_TRAP_EN.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 12;
  localparam int STARVE_LIMIT = 4;
  localparam int MEM_WORDS    = 64;

  logic              cpu_clk = 1'b0;
  logic              rst;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_ack;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [2:0]        d_type;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rden;
  logic              ram_wren;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  always #5 cpu_clk = ~cpu_clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .cpu_clk   (cpu_clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_ack     (i_ack),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_type    (d_type),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .ram_addr  (ram_addr),
    .ram_rden  (ram_rden),
    .ram_wren  (ram_wren),
    .ram_wdata (ram_wdata),
    .ram_q     (ram_q)
  );

  // Synchronous single-port RAM with a backdoor write used only for preloading.
  logic [31:0] ram [0:MEM_WORDS-1];
  logic        bkWe = 1'b0;
  logic [5:0]  bkAddr = '0;
  logic [31:0] bkData = '0;

  always @(posedge cpu_clk) begin
    if (bkWe) ram[bkAddr] <= bkData;
    else if (ram_wren) ram[ram_addr[5:0]] <= ram_wdata;
    if (ram_rden) ram_q <= ram[ram_addr[5:0]];
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } dExp_t;

  logic [31:0] refMem [0:MEM_WORDS-1];
  logic [31:0] iExpQ [$];
  dExp_t       dExpQ [$];
  int          checksTotal  = 0;
  int          checksPassed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic failNow(input string name);
    checksTotal++;
    $display("[TB] FAIL %s: got no response, expected one within the cycle bound", name);
  endtask

  // Reference model: the memory is a plain word array; accesses are shift-and-mask arithmetic.
  task automatic modelData(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int          idx, size, shift, width;
    logic [63:0] mask64;
    logic [31:0] mask, word, v;
    idx   = int'(addr[7:2]);
    size  = int'(typ[1:0]);
    rdata = '0;
    err   = 1'b0;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    if (size == 3 || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 2'b00)) begin
      err = 1'b1;
      return;
    end
`else
    if (size == 3) size = 2;
`endif
    width  = 8 << size;
    shift  = (size == 0) ? int'(addr[1:0]) * 8 : (size == 1) ? int'(addr[1]) * 16 : 0;
    mask64 = (64'd1 << width) - 64'd1;
    mask   = mask64[31:0];
    word   = refMem[idx];
    if (!we) begin
      v = (word >> shift) & mask;
      if (!typ[2] && width < 32 && v[width-1]) v = v | ~mask;
      rdata = v;
    end else begin
      refMem[idx] = (word & ~(mask << shift)) | ((wdata & mask) << shift);
    end
  endtask

  task automatic issueFetch(input logic [31:0] addr);
    i_addr = addr;
    i_req  = 1'b1;
    iExpQ.push_back(refMem[addr[7:2]]);
  endtask

  task automatic issueData(input logic we, input logic [2:0] typ, input logic [31:0] addr,
                           input logic [31:0] wdata);
    dExp_t e;
    d_we    = we;
    d_type  = typ;
    d_addr  = addr;
    d_wdata = wdata;
    d_req   = 1'b1;
    modelData(we, typ, addr, wdata, e.rdata, e.err);
    dExpQ.push_back(e);
  endtask

  task automatic waitAck(input bit isFetch, input string name);
    for (int c = 0; c < 40; c++) begin
      @(negedge cpu_clk);
      if (isFetch ? i_ack : d_ack) return;
    end
    failNow(name);
  endtask

  task automatic applyStimulus(input bit isFetch, input logic we, input logic [2:0] typ,
                               input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    if (isFetch) issueFetch(addr);
    else issueData(we, typ, addr, wdata);
    waitAck(isFetch, isFetch ? "fetch_ack_timeout" : "data_ack_timeout");
    if (!hold) begin
      if (isFetch) i_req = 1'b0;
      else d_req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  // Monitor: pops the scoreboard whenever an ack is presented.
  initial begin
    dExp_t e;
    forever begin
      @(negedge cpu_clk);
      #1;
      if (i_ack) begin
        if (iExpQ.size() == 0) failNow("i_ack_unexpected");
        else checkOutput("i_rdata", i_rdata, iExpQ.pop_front());
      end
      if (d_ack) begin
        if (dExpQ.size() == 0) failNow("d_ack_unexpected");
        else begin
          e = dExpQ.pop_front();
          checkOutput("d_rdata", d_rdata, e.rdata);
          checkOutput("d_err", 32'(d_err), 32'(e.err));
        end
      end else begin
        checkOutput("d_rdata_idle", d_rdata, 32'h0);
      end
      if (ram_rden || ram_wren)
        checkOutput("ram_addr_range", 32'(ram_addr < 12'(MEM_WORDS)), 32'h1);
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] v;
    int          op;
    rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_type = '0; d_addr = '0; d_wdata = '0;

    for (int i = 0; i < MEM_WORDS; i++) begin
      @(negedge cpu_clk);
      v = (i == 0) ? 32'h8899AABB : $urandom;
      bkWe = 1'b1; bkAddr = 6'(i); bkData = v; refMem[i] = v;
    end
    @(negedge cpu_clk);
    bkWe = 1'b0;

    $display("[TB] reset holds outputs low with both requests asserted");
    i_req = 1'b1; d_req = 1'b1; d_addr = 32'h4;
    idle(3);
    #1;
    checkOutput("rst_ram_rden", 32'(ram_rden), 32'h0);
    checkOutput("rst_ram_wren", 32'(ram_wren), 32'h0);
    checkOutput("rst_i_ack", 32'(i_ack), 32'h0);
    checkOutput("rst_d_ack", 32'(d_ack), 32'h0);
    checkOutput("rst_d_err", 32'(d_err), 32'h0);
    checkOutput("rst_d_rdata", d_rdata, 32'h0);
    checkOutput("rst_i_rdata", i_rdata, 32'h0);
    @(negedge cpu_clk);
    i_req = 1'b0; d_req = 1'b0; rst = 1'b0;
    idle(1);

    $display("[TB] lane extraction and extension");
    issueData(1'b0, 3'b000, 32'h2, 32'h0);
    #1;
    checkOutput("lb_grant_rden", 32'(ram_rden), 32'h1);
    checkOutput("lb_grant_addr", 32'(ram_addr), 32'h0);
    @(negedge cpu_clk);
    checkOutput("lb_ack", 32'(d_ack), 32'h1);
    checkOutput("lb_data", d_rdata, 32'hFFFFFF99);
    d_req = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b101, 32'h2, 32'h0, 1'b0);

    $display("[TB] sub-word store read-modify-write");
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h0, 32'h11223344, 1'b0);
    idle(1);
    issueData(1'b1, 3'b000, 32'h1, 32'hA5A5A555);
    #1;
    checkOutput("sb_n_rden", 32'(ram_rden), 32'h1);
    checkOutput("sb_n_wren", 32'(ram_wren), 32'h0);
    @(negedge cpu_clk);
    #1;
    checkOutput("sb_n1_wren", 32'(ram_wren), 32'h1);
    checkOutput("sb_n1_wdata", ram_wdata, 32'h11225544);
    checkOutput("sb_n1_ack", 32'(d_ack), 32'h0);
    @(negedge cpu_clk);
    checkOutput("sb_n2_ack", 32'(d_ack), 32'h1);
    d_req = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0);

    $display("[TB] reset during read-modify-write");
    idle(1);
    d_we = 1'b1; d_type = 3'b001; d_addr = 32'h4; d_wdata = 32'h0000BEEF; d_req = 1'b1;
    #1;
    checkOutput("rmw_rst_n_rden", 32'(ram_rden), 32'h1);
    @(negedge cpu_clk);
    rst = 1'b1;
    #1;
    checkOutput("rmw_rst_n1_wren", 32'(ram_wren), 32'h0);
    @(negedge cpu_clk);
    #1;
    checkOutput("rmw_rst_n2_wren", 32'(ram_wren), 32'h0);
    checkOutput("rmw_rst_n2_ack", 32'(d_ack), 32'h0);
    d_req = 1'b0;
    @(negedge cpu_clk);
    rst = 1'b0;
    checkOutput("rmw_rst_mem", ram[1], refMem[1]);
    idle(1);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h4, 32'h0, 1'b0);

    $display("[TB] misaligned word load");
    idle(1);
    issueData(1'b0, 3'b010, 32'h6, 32'h0);
    #1;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    checkOutput("misalign_rden", 32'(ram_rden), 32'h0);
`else
    checkOutput("misalign_rden", 32'(ram_rden), 32'h1);
`endif
    @(negedge cpu_clk);
    checkOutput("misalign_ack", 32'(d_ack), 32'h1);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    checkOutput("misalign_err", 32'(d_err), 32'h1);
`else
    checkOutput("misalign_err", 32'(d_err), 32'h0);
`endif
    d_req = 1'b0;

    $display("[TB] word store timing and fetch readback");
    idle(1);
    issueData(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    #1;
    checkOutput("sw_n_wren", 32'(ram_wren), 32'h1);
    checkOutput("sw_n_addr", 32'(ram_addr), 32'h2);
    checkOutput("sw_n_wdata", ram_wdata, 32'hDEADBEEF);
    @(negedge cpu_clk);
    checkOutput("sw_n1_ack", 32'(d_ack), 32'h1);
    d_req = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h8, 32'h0, 1'b0);

    $display("[TB] contention with both requesters held");
    idle(2);
    fork
      begin
        for (int k = 0; k < 5; k++)
          applyStimulus(1'b1, 1'b0, 3'b000, 32'(k * 4), 32'h0, k < 4);
      end
      begin
        for (int k = 0; k < 30; k++)
          applyStimulus(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        32'($urandom_range(32, 63)), $urandom, k < 29);
      end
      begin
        int dSince = 0;
        int nFetch = 0;
        int cyc = 0;
        while (nFetch < 5 && cyc < 1000) begin
          @(negedge cpu_clk);
          cyc++;
          if (d_ack) dSince++;
          if (i_ack) begin
            checkOutput("starve_gap", 32'(dSince), 32'(STARVE_LIMIT));
            dSince = 0;
            nFetch++;
          end
        end
        if (nFetch < 5) failNow("starve_tracker");
      end
    join

    $display("[TB] randomized traffic");
    idle(2);
    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 2);
      if (op == 0) applyStimulus(1'b1, 1'b0, 3'b000, 32'($urandom_range(0, 15)) << 2, 32'h0, 1'b0);
      else applyStimulus(1'b0, op == 2, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 63)),
                         $urandom, 1'b0);
      idle($urandom_range(0, 2));
    end

    for (int c = 0; c < 20 && (iExpQ.size() + dExpQ.size()) != 0; c++) @(negedge cpu_clk);
    checkOutput("queues_drained", 32'(iExpQ.size() + dExpQ.size()), 32'h0);
    idle(2);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("mem_word_%0d", i), ram[i], refMem[i]);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
